// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcode values, instruction class masks and
// architectural register numbers used by the decode stages.
package cpu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;

   // opcode[5:3] class patterns
   localparam logic [2:0] CLS_LOAD  = 3'b100;
   localparam logic [2:0] CLS_STORE = 3'b101;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/operand_bypass.sv
// Operand select: r0 reads as zero, a same-cycle writeback to the
// addressed register wins over the register file read data.
module operand_bypass #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] rf_data,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_wa,
   input  logic [DATA_W-1:0] wb_wd,
   output logic [DATA_W-1:0] val
);

   always_comb begin
      val = rf_data;
      if (addr == '0)
         val = '0;
      else if (wb_we && wb_wa == addr)
         val = wb_wd;
   end

endmodule

// File: rtl/operand_fetch.sv
// Decode / operand-fetch stage: register reads with WB bypass,
// load-use bubble insertion and the ID/EX pipeline register.
module operand_fetch
   import cpu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_valid,
   input  logic [31:0]       if_instr,
   input  logic [31:0]       if_pc,
   output logic              if_ready,
   output logic [ADDR_W-1:0] rf_ra1,
   output logic [ADDR_W-1:0] rf_ra2,
   input  logic [DATA_W-1:0] rf_rd1,
   input  logic [DATA_W-1:0] rf_rd2,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_wa,
   input  logic [DATA_W-1:0] wb_wd,
   input  logic              flush,
   input  logic              ex_ready,
   output logic              ex_valid,
   output logic [31:0]       ex_pc,
   output logic [5:0]        ex_opcode,
   output logic [5:0]        ex_funct,
   output logic [4:0]        ex_shamt,
   output logic [ADDR_W-1:0] ex_rs,
   output logic [ADDR_W-1:0] ex_rt,
   output logic [ADDR_W-1:0] ex_rd,
   output logic [DATA_W-1:0] ex_rs_val,
   output logic [DATA_W-1:0] ex_rt_val,
   output logic [31:0]       ex_imm,
   output logic              ex_is_load
);

   logic [5:0]        opcode;
   logic [5:0]        funct;
   logic [4:0]        shamt;
   logic [ADDR_W-1:0] rs;
   logic [ADDR_W-1:0] rt;
   logic [ADDR_W-1:0] rd;
   logic [ADDR_W-1:0] dst;
   logic [DATA_W-1:0] rs_val;
   logic [DATA_W-1:0] rt_val;
   logic [31:0]       imm;
   logic              is_load;
   logic              lu;
   logic              load_en;

   assign opcode  = if_instr[31:26];
   assign rs      = ADDR_W'(if_instr[25:21]);
   assign rt      = ADDR_W'(if_instr[20:16]);
   assign rd      = ADDR_W'(if_instr[15:11]);
   assign shamt   = if_instr[10:6];
   assign funct   = if_instr[5:0];
   assign imm     = {{16{if_instr[15]}}, if_instr[15:0]};
   assign is_load = (opcode[5:3] == CLS_LOAD);

   assign rf_ra1 = rs;
   assign rf_ra2 = rt;

   always_comb begin
      dst = rt;
      unique case (1'b1)
         opcode == OP_RTYPE:           dst = rd;
         opcode == OP_JAL:             dst = ADDR_W'(REG_RA);
         opcode[5:3] == CLS_STORE:     dst = ADDR_W'(REG_ZERO);
         opcode == OP_BEQ,
         opcode == OP_BNE:             dst = ADDR_W'(REG_ZERO);
         default:                      dst = rt;
      endcase
   end

   operand_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_rs (
      .addr    (rs),
      .rf_data (rf_rd1),
      .wb_we   (wb_we),
      .wb_wa   (wb_wa),
      .wb_wd   (wb_wd),
      .val     (rs_val)
   );

   operand_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_rt (
      .addr    (rt),
      .rf_data (rf_rd2),
      .wb_we   (wb_we),
      .wb_wa   (wb_wa),
      .wb_wd   (wb_wd),
      .val     (rt_val)
   );

   // rt is compared even for I-types: conservative but cheap
   assign lu = ex_valid && ex_is_load && ex_rd != '0 &&
               (ex_rd == rs || ex_rd == rt);

   assign if_ready = flush || (ex_ready && !lu);
   assign load_en  = !flush && ex_ready && !lu;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid   <= 1'b0;
         ex_pc      <= '0;
         ex_opcode  <= '0;
         ex_funct   <= '0;
         ex_shamt   <= '0;
         ex_rs      <= '0;
         ex_rt      <= '0;
         ex_rd      <= '0;
         ex_rs_val  <= '0;
         ex_rt_val  <= '0;
         ex_imm     <= '0;
         ex_is_load <= 1'b0;
      end else if (load_en) begin
         ex_valid   <= if_valid;
         ex_pc      <= if_pc;
         ex_opcode  <= opcode;
         ex_funct   <= funct;
         ex_shamt   <= shamt;
         ex_rs      <= rs;
         ex_rt      <= rt;
         ex_rd      <= dst;
         ex_rs_val  <= rs_val;
         ex_rt_val  <= rt_val;
         ex_imm     <= imm;
         ex_is_load <= is_load;
      end else if (flush || (ex_ready && lu)) begin
         ex_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register file.
module tb_operand_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_ready;
   logic [4:0]  rf_ra1, rf_ra2;
   logic [31:0] rf_rd1, rf_rd2;
   logic        wb_we;
   logic [4:0]  wb_wa;
   logic [31:0] wb_wd;
   logic        flush;
   logic        ex_ready;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [5:0]  ex_opcode, ex_funct;
   logic [4:0]  ex_shamt;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
   logic [31:0] ex_rs_val, ex_rt_val, ex_imm;
   logic        ex_is_load;

   logic [31:0] rf [32];
   int vectors = 0;
   int miscompares = 0;

   assign rf_rd1 = rf[rf_ra1];
   assign rf_rd2 = rf[rf_ra2];

   always #5 clk = ~clk;

   operand_fetch #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .if_ready(if_ready),
      .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
      .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
      .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
      .flush(flush), .ex_ready(ex_ready),
      .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_opcode(ex_opcode), .ex_funct(ex_funct), .ex_shamt(ex_shamt),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
      .ex_imm(ex_imm), .ex_is_load(ex_is_load)
   );

   function automatic logic [31:0] r_add(input logic [4:0] d,
                                         input logic [4:0] s,
                                         input logic [4:0] t);
      return {6'h00, s, t, d, 5'd0, 6'h20};
   endfunction

   function automatic logic [31:0] i_fmt(input logic [5:0] op,
                                         input logic [4:0] s,
                                         input logic [4:0] t,
                                         input logic [15:0] im);
      return {op, s, t, im};
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      vectors++;
      if (ex_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_valid: got %b want 0", ex_valid);
      end
      vectors++;
      if ({ex_pc, ex_rd, ex_rs_val, ex_imm} !== '0) begin
         miscompares++;
         $display("FAIL reset_fields: got %h/%h/%h/%h want 0",
                  ex_pc, ex_rd, ex_rs_val, ex_imm);
      end
      vectors++;
      if (if_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_if_ready: got %b want 1", if_ready);
      end
   endtask

   task automatic test_bypass;
      @(negedge clk);
      rf[5] = 32'd11;
      if_valid = 1'b1;
      if_instr = r_add(5'd7, 5'd5, 5'd5);
      if_pc = 32'h100;
      wb_we = 1'b1; wb_wa = 5'd5; wb_wd = 32'd22;
      #1;
      vectors++;
      if (rf_ra1 !== 5'd5 || rf_ra2 !== 5'd5) begin
         miscompares++;
         $display("FAIL ra: got %0d,%0d want 5,5", rf_ra1, rf_ra2);
      end
      step();
      vectors++;
      if (ex_rs_val !== 32'd22 || ex_rt_val !== 32'd22) begin
         miscompares++;
         $display("FAIL bypass_val: got %0d,%0d want 22,22",
                  ex_rs_val, ex_rt_val);
      end
      vectors++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || ex_pc !== 32'h100) begin
         miscompares++;
         $display("FAIL bypass_ctl: got v%b rd%0d pc%h want v1 rd7 pc100",
                  ex_valid, ex_rd, ex_pc);
      end
      vectors++;
      if (ex_funct !== 6'h20 || ex_opcode !== 6'h00) begin
         miscompares++;
         $display("FAIL bypass_fields: got %h/%h want 20/00",
                  ex_funct, ex_opcode);
      end
      @(negedge clk);
      wb_wa = 5'd6;
      if_pc = 32'h104;
      step();
      vectors++;
      if (ex_rs_val !== 32'd11 || ex_rt_val !== 32'd11) begin
         miscompares++;
         $display("FAIL nobypass_val: got %0d,%0d want 11,11",
                  ex_rs_val, ex_rt_val);
      end
   endtask

   task automatic test_r0;
      @(negedge clk);
      if_instr = i_fmt(6'h08, 5'd0, 5'd0, 16'hFFFF);
      if_pc = 32'h108;
      wb_we = 1'b1; wb_wa = 5'd0; wb_wd = 32'd99;
      step();
      vectors++;
      if (ex_rs_val !== 32'd0 || ex_rt_val !== 32'd0) begin
         miscompares++;
         $display("FAIL r0_val: got %0d,%0d want 0,0",
                  ex_rs_val, ex_rt_val);
      end
      vectors++;
      if (ex_imm !== 32'hFFFF_FFFF || ex_rd !== 5'd0) begin
         miscompares++;
         $display("FAIL r0_imm_rd: got %h rd%0d want ffffffff rd0",
                  ex_imm, ex_rd);
      end
      wb_we = 1'b0;
   endtask

   task automatic test_dest;
      logic [5:0] ops [5] = '{6'h03, 6'h2B, 6'h04, 6'h05, 6'h0D};
      logic [4:0] exp [5] = '{5'd31, 5'd0, 5'd0, 5'd0, 5'd12};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if_instr = i_fmt(ops[i], 5'd3, 5'd12, 16'h7000);
         step();
         vectors++;
         if (ex_rd !== exp[i] || ex_is_load !== 1'b0) begin
            miscompares++;
            $display("FAIL dest op%h: got rd%0d ld%b want rd%0d ld0",
                     ops[i], ex_rd, ex_is_load, exp[i]);
         end
      end
   endtask

   task automatic test_load_use;
      @(negedge clk);
      rf[1] = 32'd100; rf[2] = 32'd5;
      if_instr = i_fmt(6'h23, 5'd1, 5'd8, 16'h0000);
      if_pc = 32'h200;
      step();
      vectors++;
      if (ex_is_load !== 1'b1 || ex_rd !== 5'd8 || ex_rs_val !== 32'd100) begin
         miscompares++;
         $display("FAIL lw: got ld%b rd%0d rs%0d want ld1 rd8 rs100",
                  ex_is_load, ex_rd, ex_rs_val);
      end
      @(negedge clk);
      if_instr = r_add(5'd9, 5'd8, 5'd2);
      if_pc = 32'h204;
      #1;
      vectors++;
      if (if_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL lu_stall: got if_ready %b want 0", if_ready);
      end
      step();
      vectors++;
      if (ex_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL lu_bubble: got ex_valid %b want 0", ex_valid);
      end
      @(negedge clk);
      vectors++;
      if (if_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL lu_release: got if_ready %b want 1", if_ready);
      end
      step();
      vectors++;
      if (ex_valid !== 1'b1 || ex_rs !== 5'd8 || ex_rd !== 5'd9 ||
          ex_pc !== 32'h204) begin
         miscompares++;
         $display("FAIL lu_dep: got v%b rs%0d rd%0d pc%h want v1 rs8 rd9 pc204",
                  ex_valid, ex_rs, ex_rd, ex_pc);
      end
   endtask

   task automatic test_backpressure;
      @(negedge clk);
      if_instr = r_add(5'd3, 5'd1, 5'd2);
      if_pc = 32'h300;
      step();
      @(negedge clk);
      ex_ready = 1'b0;
      if_instr = r_add(5'd4, 5'd1, 5'd2);
      if_pc = 32'h304;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++;
         if (if_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_ready[%0d]: got %b want 0", i, if_ready);
         end
         step();
         vectors++;
         if (ex_valid !== 1'b1 || ex_rd !== 5'd3 || ex_pc !== 32'h300) begin
            miscompares++;
            $display("FAIL bp_hold[%0d]: got v%b rd%0d pc%h want v1 rd3 pc300",
                     i, ex_valid, ex_rd, ex_pc);
         end
         @(negedge clk);
      end
      ex_ready = 1'b1;
      step();
      vectors++;
      if (ex_rd !== 5'd4 || ex_pc !== 32'h304) begin
         miscompares++;
         $display("FAIL bp_accept: got rd%0d pc%h want rd4 pc304",
                  ex_rd, ex_pc);
      end
   endtask

   task automatic test_flush;
      @(negedge clk);
      if_instr = i_fmt(6'h23, 5'd1, 5'd8, 16'h0004);
      if_pc = 32'h400;
      step();
      @(negedge clk);
      if_instr = r_add(5'd9, 5'd8, 5'd2);
      if_pc = 32'h404;
      flush = 1'b1;
      #1;
      vectors++;
      if (if_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_ready: got %b want 1", if_ready);
      end
      step();
      vectors++;
      if (ex_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_squash: got ex_valid %b want 0", ex_valid);
      end
      @(negedge clk);
      flush = 1'b0;
      if_valid = 1'b0;
      if_instr = 32'h0;
      step();
      vectors++;
      if (ex_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL flush_gone: got ex_valid %b want 0", ex_valid);
      end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      if_valid = 1'b1;
      if_instr = i_fmt(6'h23, 5'd1, 5'd8, 16'h0008);
      if_pc = 32'h500;
      step();
      @(negedge clk);
      if_instr = r_add(5'd9, 5'd8, 5'd2);
      if_pc = 32'h504;
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (ex_valid !== 1'b0 || ex_is_load !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_async_ctl: got v%b ld%b want 0 0",
                  ex_valid, ex_is_load);
      end
      vectors++;
      if ({ex_pc, ex_rd, ex_rs_val, ex_imm} !== '0) begin
         miscompares++;
         $display("FAIL rst_async_fields: got %h/%h/%h/%h want 0",
                  ex_pc, ex_rd, ex_rs_val, ex_imm);
      end
      vectors++;
      if (if_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_ready: got %b want 1", if_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      vectors++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'd9 || ex_pc !== 32'h504) begin
         miscompares++;
         $display("FAIL rst_release: got v%b rd%0d pc%h want v1 rd9 pc504",
                  ex_valid, ex_rd, ex_pc);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'd3;
      rst_n = 1'b0;
      if_valid = 1'b0;
      if_instr = 32'h0;
      if_pc = 32'h0;
      wb_we = 1'b0; wb_wa = 5'd0; wb_wd = 32'h0;
      flush = 1'b0;
      ex_ready = 1'b1;
      #2;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_bypass();
      test_r0();
      test_dest();
      test_load_use();
      test_backpressure();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
